// File: rtl/sample_frame_pkg.sv
// sample_frame_pkg: shared constants, state encoding and frame-length helper for the frame reader
package sample_frame_pkg;
  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  typedef enum logic [2:0] {IDLE, HEADER, CHAN_ID, SAMPLE, CHECKSUM} state_t;
  function automatic int frame_len(input int num_channels, input int samples);
    return 2 + num_channels * (1 + samples);
  endfunction
endpackage

// File: rtl/sample_frame_reader.sv
// sample_frame_reader: snapshots the sample window on start and streams it as a framed, checksummed byte sequence
module sample_frame_reader
  import sample_frame_pkg::*;
#(
  parameter int NUM_CHANNELS = 7,
  parameter int SAMPLES = 10,
  parameter int SAMPLE_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [NUM_CHANNELS*SAMPLES*SAMPLE_BITS-1:0] window_in,
  output logic [7:0] data_out,
  output logic data_valid,
  input  logic data_ready,
  output logic busy,
  output logic frame_done
);
  localparam int W = NUM_CHANNELS * SAMPLES * SAMPLE_BITS;
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int SW = SAMPLES > 1 ? $clog2(SAMPLES) : 1;
  localparam int BW = NUM_CHANNELS * SAMPLES > 1 ? $clog2(NUM_CHANNELS * SAMPLES) : 1;
  if (SAMPLE_BITS != 8) begin : g_bad_width
    $error("sample_frame_reader: SAMPLE_BITS must be 8");
  end
  state_t state, nxt_state;
  logic [CW-1:0] ch, nxt_ch;
  logic [SW-1:0] smp, nxt_smp;
  logic [7:0] sum, nxt_sum, nxt_byte;
  logic [BW-1:0] byte_idx;
  logic [W-1:0] snap;
  logic xfer, last_smp, last_ch;
  assign xfer = data_valid && data_ready;
  assign busy = state != IDLE;
  assign last_smp = smp == SW'(SAMPLES - 1);
  assign last_ch = ch == CW'(NUM_CHANNELS - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      smp <= '0;
      sum <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt_state;
      ch <= nxt_ch;
      smp <= nxt_smp;
      sum <= nxt_sum;
      data_out <= nxt_byte;
      data_valid <= nxt_state != IDLE;
      frame_done <= state == CHECKSUM && xfer;
    end
  end
  always_ff @(posedge clk)
    if (state == IDLE && start) snap <= window_in;
  always_comb begin
    nxt_state = state;
    nxt_ch = ch;
    nxt_smp = smp;
    nxt_sum = sum;
    case (state)
      IDLE: if (start) begin
        nxt_state = HEADER;
        nxt_ch = '0;
        nxt_smp = '0;
        nxt_sum = '0;
      end
      HEADER: if (xfer) nxt_state = CHAN_ID;
      CHAN_ID: if (xfer) begin
        nxt_state = SAMPLE;
        nxt_sum = sum + data_out;
      end
      SAMPLE: if (xfer) begin
        nxt_sum = sum + data_out;
        nxt_smp = last_smp ? '0 : smp + 1'b1;
        nxt_ch = !last_smp ? ch : last_ch ? '0 : ch + 1'b1;
        nxt_state = !last_smp ? SAMPLE : last_ch ? CHECKSUM : CHAN_ID;
      end
      CHECKSUM: if (xfer) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end
  // The byte for the upcoming state is computed here and registered, so data_out is stable across stalls
  always_comb begin
    byte_idx = BW'(nxt_ch) * BW'(SAMPLES) + BW'(nxt_smp);
    nxt_byte = nxt_state == HEADER ? FRAME_HEADER :
               nxt_state == CHAN_ID ? 8'(nxt_ch) :
               nxt_state == SAMPLE ? snap[{byte_idx, 3'b000} +: 8] :
               nxt_state == CHECKSUM ? nxt_sum : 8'h00;
  end
endmodule

// File: tb/tb_sample_frame_reader.sv
// tb_sample_frame_reader: randomized directed bench comparing streamed frames against a queue-based frame model
module tb_sample_frame_reader;
  import sample_frame_pkg::*;
  localparam int NC = 7;
  localparam int NS = 10;
  localparam int W = NC * NS * 8;
  localparam int LEN = frame_len(NC, NS);
  logic clk = 1'b0;
  logic reset, start, data_ready, data_valid, busy, frame_done;
  logic [7:0] data_out;
  logic [W-1:0] window_in;
  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  sample_frame_reader #(.NUM_CHANNELS(NC), .SAMPLES(NS), .SAMPLE_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .window_in(window_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] w);
    logic [7:0] s = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int c = 0; c < NC; c++) begin
      exp_q.push_back(8'(c));
      s += 8'(c);
      for (int k = 0; k < NS; k++) begin
        exp_q.push_back(w[(c * NS + k) * 8 +: 8]);
        s += w[(c * NS + k) * 8 +: 8];
      end
    end
    exp_q.push_back(s);
  endfunction
  function automatic logic [W-1:0] rand_window();
    logic [W-1:0] w;
    for (int i = 0; i < NC * NS; i++) w[i * 8 +: 8] = 8'($urandom);
    return w;
  endfunction
  function automatic logic [W-1:0] pattern_window();
    logic [W-1:0] w;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NS; k++) w[(c * NS + k) * 8 +: 8] = 8'(c * 16 + k);
    return w;
  endfunction
  function automatic logic [7:0] gb(input int i);
    return i < got.size() ? got[i] : 8'hxx;
  endfunction
  // mode 0: ready tied high; mode 1: random ready with occasional 5-cycle stalls
  task automatic run(input bit do_start, input int mode, input bit scramble, input bit busy_starts,
                     input bit chain, input int abort_at);
    int cyc = 0, stall = 0, last_x = -1;
    bit was_stall = 0;
    logic [7:0] held = 8'h00;
    got.delete();
    done_cnt = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      data_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk("latency_valid", data_valid, 1);
    chk("latency_header", data_out, 8'hA5);
    chk("latency_busy", busy, 1);
    while (cyc < 600) begin
      start = 1'b0;
      if (scramble) window_in = rand_window();
      if (frame_done) begin
        done_cnt++;
        chk("done_valid_low", data_valid, 0);
        chk("done_busy_low", busy, 0);
        chk("done_after_checksum", cyc, last_x + 1);
        if (mode == 0) chk("frame_cycles", cyc, LEN);
        if (chain) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        break;
      end
      if (abort_at >= 0 && got.size() == abort_at) begin
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("abort_data", data_out, 8'h00);
        chk("abort_valid", data_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", frame_done, 0);
        @(negedge clk);
        chk("abort_no_done", frame_done, 0);
        chk("abort_stays_idle", data_valid, 0);
        return;
      end
      if (was_stall) begin
        chk("stall_valid", data_valid, 1);
        chk("stall_data", data_out, held);
      end
      if (mode == 0) data_ready = 1'b1;
      else if (stall > 0) begin
        data_ready = 1'b0;
        stall--;
      end else if ($urandom_range(7) == 0) begin
        data_ready = 1'b0;
        stall = 4;
      end else data_ready = 1'($urandom);
      if (busy_starts && busy) start = 1'($urandom);
      was_stall = data_valid && !data_ready;
      held = data_out;
      if (data_valid && data_ready) begin
        got.push_back(data_out);
        last_x = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_count", done_cnt, 1);
    chk("frame_len", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("byte[%0d]", i), gb(i), exp_q[i]);
    if (!chain)
      repeat (3) begin
        @(negedge clk);
        chk("done_once", frame_done, 0);
        chk("no_extra_frame", data_valid, 0);
      end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    start = 1'b0;
    data_ready = 1'b0;
    window_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_data", data_out, 8'h00);
    chk("reset_valid", data_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", data_valid, 0);
    model(window_in);
    run(1, 0, 0, 0, 0, -1);
    chk("zero_checksum", gb(LEN - 1), 8'h15);
    window_in = pattern_window();
    model(window_in);
    run(1, 0, 0, 0, 0, -1);
    chk("pattern_byte2", gb(2), 8'h00);
    chk("pattern_byte77", gb(77), 8'h69);
    chk("pattern_checksum", gb(78), 8'h70);
    run(1, 1, 0, 0, 0, -1);
    window_in = rand_window();
    model(window_in);
    run(1, 1, 1, 0, 0, -1);
    window_in = rand_window();
    model(window_in);
    run(1, 1, 0, 1, 0, -1);
    window_in = rand_window();
    model(window_in);
    run(1, 0, 0, 0, 1, -1);
    run(0, 0, 0, 0, 0, -1);
    window_in = rand_window();
    model(window_in);
    run(1, 1, 0, 0, 0, 30);
    window_in = rand_window();
    model(window_in);
    run(1, 0, 0, 0, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_frame_reader.md
# sample_frame_reader

Read-side companion to the multichannel sample history buffer. On a start pulse it snapshots the flattened window of all channels. It then streams the snapshot out as a framed byte sequence (header, per-channel ID plus samples oldest-first, checksum) over a valid/ready byte interface. Typical sinks are the `uio_out` pins or a UART shim.

## Interface
- `NUM_CHANNELS`, default 7: number of channels in the window.
- `SAMPLES`, default 10: samples per channel.
- `SAMPLE_BITS`, default 8: bits per sample. Fixed at 8; elaboration error otherwise.
- `clk` input 1: single clock, all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request to snapshot and send a frame.
- `window_in` input NUM_CHANNELS*SAMPLES*8: flattened buffer.
  - Channel c occupies `[c*SAMPLES*8 +: SAMPLES*8]`.
  - Within a channel, sample s occupies `[s*8 +: 8]`; s=0 is oldest.
- `data_out` output 8: current frame byte.
- `data_valid` output 1: `data_out` holds a byte.
- `data_ready` input 1: sink accepts the byte.
- `busy` output 1: frame in progress; high from the cycle after an accepted start through the final transfer.
- `frame_done` output 1: one-cycle pulse after the checksum byte transfers.

## Operation
- Frame format:
  - header 0xA5;
  - for c = 0..NUM_CHANNELS-1: channel-ID byte c, then SAMPLES bytes s = 0..SAMPLES-1;
  - checksum byte.
  - Length = 2 + NUM_CHANNELS*(1+SAMPLES), i.e. 79 bytes at defaults.
- Checksum = sum mod 256 of every byte after the header, excluding the checksum itself.
- States:
  - IDLE: `start` captures `window_in` into the snapshot register and moves to HEADER.
  - HEADER: after transfer, go to CHAN_ID.
  - CHAN_ID: after transfer, go to SAMPLE.
  - SAMPLE: after transfer of the last sample, go to CHAN_ID if channels remain, else CHECKSUM.
  - CHECKSUM: after transfer, go to IDLE with `frame_done`.
- A transfer is a cycle with `data_valid && data_ready`. Counters and the checksum advance only on transfers.
- The snapshot is frozen for the whole frame. Changes on `window_in` after the capture cycle never appear in the frame.
- `start` is ignored while `busy`; no queuing.
- Counters: channel index is clog2(NUM_CHANNELS) bits, sample index is clog2(SAMPLES) bits, checksum accumulator is 8 bits and wraps.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `busy`=0, `frame_done`=0. State is IDLE, counters and checksum are 0.
- Latency: `start` sampled high at edge N gives `data_valid`=1 with `data_out`=0xA5 and `busy`=1 after edge N.
- While `data_valid && !data_ready`, `data_out` is held stable and `data_valid` stays high. `data_valid` never drops without a transfer.
- With `data_ready` tied high, one byte transfers per cycle and the frame takes exactly 79 consecutive cycles.
- After the checksum transfer: `data_valid`=0, `busy`=0 and `frame_done`=1, all in the same cycle, for one cycle.
- A `start` in the `frame_done` cycle is accepted, so back-to-back frames have one idle cycle between them.
- Reset mid-frame aborts the frame:
  - outputs return to reset values on the next edge;
  - no `frame_done`, no partial checksum;
  - reset dominates a simultaneous `start`.
- `data_out` and `data_valid` are registered; no combinational path from `data_ready` to outputs.

## Structure
- Shared package `sample_frame_pkg` holds:
  - `FRAME_HEADER` = 8'hA5;
  - the state enum (IDLE, HEADER, CHAN_ID, SAMPLE, CHECKSUM);
  - a `frame_len(NUM_CHANNELS, SAMPLES)` function for bench reuse.
- Single module; no sub-module is warranted. Byte selection from the snapshot is an indexed part-select driven by the channel and sample counters.

## Test plan
- All-zero window, `data_ready`=1, `start` pulse:
  - 79 bytes: A5, 00, 00×10, 01, 00×10, …, 06, 00×10, then checksum 0x15;
  - `frame_done` fires once, one cycle after the checksum.
- Window with channel c, sample s = c*16+s, `data_ready`=1:
  - byte 2 = 0x00, byte 77 = 0x69, checksum = 0x70;
  - each channel's 10 samples appear oldest-first.
- Same window with `data_ready` toggled pseudo-randomly, including 5-cycle stalls: identical byte sequence, `data_out` stable during every stall.
- Change `window_in` every cycle after `start`: the frame matches the capture-cycle value only.
- Pulse `start` repeatedly while busy: exactly one frame. A `start` in the `frame_done` cycle gives a second frame with A5 on the next cycle.
- Assert `reset` at byte 30: next cycle all outputs are 0 and there is no `frame_done`. A subsequent `start` produces a complete, correct 79-byte frame.
